// File: rtl/fabric_cfg_pkg.sv
// Shared constants for the fabric configuration loader: state codes,
// CRC-8 polynomial, default geometry and small sizing helpers.
package fabric_cfg_pkg;

  localparam int DEF_NUM_TILES = 20;
  localparam int DEF_NUM_SBOX  = 4;
  localparam int DEF_TILE_W    = 33;
  localparam int DEF_SBOX_W    = 16;
  localparam int CRC_W         = 8;

  localparam logic [7:0] CRC_POLY = 8'h07;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD_TILE = 3'd1;
  localparam logic [2:0] ST_LOAD_SBOX = 3'd2;
  localparam logic [2:0] ST_CHECK     = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;
  localparam logic [2:0] ST_ERROR     = 3'd5;

  // A single-entry table still needs a one-bit address port.
  function automatic int addr_w(input int n);
    addr_w = (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    max3 = (m > c) ? m : c;
  endfunction

  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic b);
    crc8_next = {crc[6:0], 1'b0} ^ ((crc[7] ^ b) ? CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 (MSB first, init 0) over the configuration payload.
module crc8_serial
  import fabric_cfg_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      crc <= '0;
    end else if (clear) begin
      crc <= '0;
    end else if (en) begin
      crc <= crc8_next(crc, bit_in);
    end
  end

endmodule

// File: rtl/fabric_config_ctrl.sv
// Serial bitstream loader: shifts tile and switch-box words in MSB first,
// strobes each completed word out, then checks a trailing CRC-8.
module fabric_config_ctrl
  import fabric_cfg_pkg::*;
#(
  parameter int NUM_TILES = DEF_NUM_TILES,
  parameter int NUM_SBOX  = DEF_NUM_SBOX,
  parameter int TILE_W    = DEF_TILE_W,
  parameter int SBOX_W    = DEF_SBOX_W
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          cfg_bit,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  output logic                          tile_wr_en,
  output logic [addr_w(NUM_TILES)-1:0]  tile_wr_addr,
  output logic [TILE_W-1:0]             tile_wr_data,
  output logic                          sbox_wr_en,
  output logic [addr_w(NUM_SBOX)-1:0]   sbox_wr_addr,
  output logic [SBOX_W-1:0]             sbox_wr_data,
  output logic                          fabric_enable,
  output logic                          busy,
  output logic                          done,
  output logic                          error
);

  localparam int TILE_AW = addr_w(NUM_TILES);
  localparam int SBOX_AW = addr_w(NUM_SBOX);
  localparam int SHIFT_W = max3(TILE_W, SBOX_W, CRC_W);
  localparam int BIT_CW  = $clog2(SHIFT_W + 1);
  localparam int WORD_CW = $clog2(max3(NUM_TILES, NUM_SBOX, 1) + 1);

  localparam logic [BIT_CW-1:0]  TILE_LAST  = BIT_CW'(TILE_W - 1);
  localparam logic [BIT_CW-1:0]  SBOX_LAST  = BIT_CW'(SBOX_W - 1);
  localparam logic [BIT_CW-1:0]  CRC_LAST   = BIT_CW'(CRC_W - 1);
  localparam logic [WORD_CW-1:0] TILE_WLAST = WORD_CW'(NUM_TILES - 1);
  localparam logic [WORD_CW-1:0] SBOX_WLAST = WORD_CW'(NUM_SBOX - 1);

  logic [2:0]         state;
  logic [BIT_CW-1:0]  bit_cnt;
  logic [WORD_CW-1:0] word_cnt;
  logic [SHIFT_W-2:0] shift;
  logic [SHIFT_W-1:0] shift_next;
  logic [7:0]         crc;
  logic               in_load;
  logic               can_start;
  logic               accept;
  logic               crc_clear;
  logic               crc_en;

  // Handshake: a bit transfers on a rising edge when cfg_valid && cfg_ready;
  // cfg_ready depends only on state, and abort suppresses the transfer.
  assign in_load   = (state == ST_LOAD_TILE) || (state == ST_LOAD_SBOX) || (state == ST_CHECK);
  assign cfg_ready = in_load;
  assign busy      = in_load;
  assign done      = (state == ST_DONE);
  assign fabric_enable = done;
  assign error     = (state == ST_ERROR);

  assign accept     = cfg_valid && cfg_ready && !abort;
  assign can_start  = start && !abort &&
                      ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
  assign shift_next = {shift, cfg_bit};
  assign crc_clear  = abort || can_start;
  assign crc_en     = accept && ((state == ST_LOAD_TILE) || (state == ST_LOAD_SBOX));

  crc8_serial u_crc (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (crc_clear),
    .en      (crc_en),
    .bit_in  (cfg_bit),
    .crc     (crc)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      word_cnt     <= '0;
      shift        <= '0;
      tile_wr_en   <= 1'b0;
      tile_wr_addr <= '0;
      tile_wr_data <= '0;
      sbox_wr_en   <= 1'b0;
      sbox_wr_addr <= '0;
      sbox_wr_data <= '0;
    end else begin
      tile_wr_en <= 1'b0;
      sbox_wr_en <= 1'b0;
      if (accept) begin
        shift <= shift_next[SHIFT_W-2:0];
      end
      if (abort) begin
        state    <= ST_IDLE;
        bit_cnt  <= '0;
        word_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) begin
              state    <= ST_LOAD_TILE;
              bit_cnt  <= '0;
              word_cnt <= '0;
              shift    <= '0;
            end
          end
          ST_LOAD_TILE: begin
            if (accept) begin
              if (bit_cnt == TILE_LAST) begin
                tile_wr_en   <= 1'b1;
                tile_wr_addr <= word_cnt[TILE_AW-1:0];
                tile_wr_data <= shift_next[TILE_W-1:0];
                bit_cnt      <= '0;
                if (word_cnt == TILE_WLAST) begin
                  word_cnt <= '0;
                  state    <= ST_LOAD_SBOX;
                end else begin
                  word_cnt <= word_cnt + 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          ST_LOAD_SBOX: begin
            if (accept) begin
              if (bit_cnt == SBOX_LAST) begin
                sbox_wr_en   <= 1'b1;
                sbox_wr_addr <= word_cnt[SBOX_AW-1:0];
                sbox_wr_data <= shift_next[SBOX_W-1:0];
                bit_cnt      <= '0;
                if (word_cnt == SBOX_WLAST) begin
                  word_cnt <= '0;
                  state    <= ST_CHECK;
                end else begin
                  word_cnt <= word_cnt + 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          ST_CHECK: begin
            if (accept) begin
              if (bit_cnt == CRC_LAST) begin
                bit_cnt <= '0;
                state   <= (shift_next[CRC_W-1:0] == crc) ? ST_DONE : ST_ERROR;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fabric_config_ctrl.sv
// Randomized scoreboard bench for fabric_config_ctrl (2 tiles, 1 switch box).
module tb_fabric_config_ctrl;

  localparam int NT    = 2;
  localparam int NS    = 1;
  localparam int TW    = 33;
  localparam int SW    = 16;
  localparam int TAW   = 1;
  localparam int SAW   = 1;
  localparam int NBITS = NT * TW + NS * SW;

  logic           clock = 1'b0;
  logic           reset_n;
  logic           start;
  logic           abort;
  logic           cfg_bit;
  logic           cfg_valid;
  logic           cfg_ready;
  logic           tile_wr_en;
  logic [TAW-1:0] tile_wr_addr;
  logic [TW-1:0]  tile_wr_data;
  logic           sbox_wr_en;
  logic [SAW-1:0] sbox_wr_addr;
  logic [SW-1:0]  sbox_wr_data;
  logic           fabric_enable;
  logic           busy;
  logic           done;
  logic           error;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit stalled = 0;

  logic [TAW+TW-1:0] exp_tile_q[$];
  int                exp_tile_cyc[$];
  logic [SAW+SW-1:0] exp_sbox_q[$];
  int                exp_sbox_cyc[$];

  logic [TW-1:0] tile_words[NT];
  logic [SW-1:0] sbox_words[NS];

  fabric_config_ctrl #(
    .NUM_TILES (NT),
    .NUM_SBOX  (NS),
    .TILE_W    (TW),
    .SBOX_W    (SW)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .abort         (abort),
    .cfg_bit       (cfg_bit),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .tile_wr_en    (tile_wr_en),
    .tile_wr_addr  (tile_wr_addr),
    .tile_wr_data  (tile_wr_data),
    .sbox_wr_en    (sbox_wr_en),
    .sbox_wr_addr  (sbox_wr_addr),
    .sbox_wr_data  (sbox_wr_data),
    .fabric_enable (fabric_enable),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  // Reference CRC: remainder of payload * x^8 divided by x^8+x^2+x+1.
  function automatic logic [7:0] model_crc(input logic [TW-1:0] tw[NT], input logic [SW-1:0] sw[NS]);
    int r;
    int b;
    logic payload[$];
    for (int t = 0; t < NT; t++)
      for (int i = TW - 1; i >= 0; i--) payload.push_back(tw[t][i]);
    for (int s = 0; s < NS; s++)
      for (int i = SW - 1; i >= 0; i--) payload.push_back(sw[s][i]);
    r = 0;
    for (int i = 0; i < NBITS + 8; i++) begin
      b = (i < NBITS) ? int'(payload[i]) : 0;
      r = (r << 1) | b;
      if ((r & 256) != 0) r = r ^ 263;
    end
    return 8'(r);
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (tile_wr_en) begin
      if (exp_tile_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL tile_unexpected: got strobe addr %0d data %0h, required no strobe",
                 tile_wr_addr, tile_wr_data);
      end else begin
        chk("tile_word", {tile_wr_addr, tile_wr_data}, exp_tile_q.pop_front());
        chk("tile_cycle", cyc, exp_tile_cyc.pop_front());
      end
    end
    if (sbox_wr_en) begin
      if (exp_sbox_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sbox_unexpected: got strobe addr %0d data %0h, required no strobe",
                 sbox_wr_addr, sbox_wr_data);
      end else begin
        chk("sbox_word", {sbox_wr_addr, sbox_wr_data}, exp_sbox_q.pop_front());
        chk("sbox_cycle", cyc, exp_sbox_cyc.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b, input int gap, output int acc_cyc);
    int   waited;
    logic rdy;
    waited = 0;
    repeat (gap) begin
      cfg_valid = 1'b0;
      cfg_bit   = 1'($urandom_range(0, 1));
      sync();
    end
    cfg_valid = 1'b1;
    cfg_bit   = b;
    acc_cyc   = -1;
    while (acc_cyc < 0 && waited < 20) begin
      @(negedge clock);
      rdy = cfg_ready;
      sync();
      if (rdy) acc_cyc = cyc;
      waited++;
    end
    cfg_valid = 1'b0;
    if (acc_cyc < 0) begin
      total++;
      bad++;
      stalled = 1;
      $display("FAIL accept_timeout: cfg_ready stayed 0 for 20 cycles, required 1");
    end
  endtask

  // Sends bits [first, last) of the stream built from tile_words/sbox_words
  // plus an 8-bit trailer (model CRC xor trailer_xor); last < 0 means all.
  task automatic run_load(input int gap_mode, input logic [7:0] trailer_xor,
                          input int first, input int last);
    logic       q[$];
    logic [7:0] trailer;
    int         n;
    int         ac;
    int         gap;
    for (int t = 0; t < NT; t++)
      for (int i = TW - 1; i >= 0; i--) q.push_back(tile_words[t][i]);
    for (int s = 0; s < NS; s++)
      for (int i = SW - 1; i >= 0; i--) q.push_back(sbox_words[s][i]);
    trailer = model_crc(tile_words, sbox_words) ^ trailer_xor;
    for (int i = 7; i >= 0; i--) q.push_back(trailer[i]);
    n = (last < 0) ? q.size() : last;
    stalled = 0;
    for (int k = first; k < n; k++) begin
      gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : $urandom_range(0, 2);
      send_bit(q[k], gap, ac);
      if (stalled) break;
      if (k < NT * TW && ((k + 1) % TW) == 0) begin
        exp_tile_q.push_back({TAW'((k + 1) / TW - 1), tile_words[(k + 1) / TW - 1]});
        exp_tile_cyc.push_back(ac);
      end else if (k >= NT * TW && k < NBITS && ((k + 1 - NT * TW) % SW) == 0) begin
        exp_sbox_q.push_back({SAW'((k + 1 - NT * TW) / SW - 1), sbox_words[(k + 1 - NT * TW) / SW - 1]});
        exp_sbox_cyc.push_back(ac);
      end
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    sync();
    start = 1'b0;
    @(negedge clock);
    chk("start_busy", busy, 1'b1);
    chk("start_ready", cfg_ready, 1'b1);
    chk("start_done_clear", {done, error, fabric_enable}, 3'b000);
    sync();
  endtask

  task automatic check_outcome(input string tag, input bit exp_good);
    @(negedge clock);
    chk({tag, "_done"}, done, exp_good);
    chk({tag, "_error"}, error, !exp_good);
    chk({tag, "_fabric_enable"}, fabric_enable, exp_good);
    chk({tag, "_idle"}, {busy, cfg_ready}, 2'b00);
    sync();
  endtask

  task automatic random_words();
    for (int t = 0; t < NT; t++) tile_words[t] = {1'($urandom_range(0, 1)), 32'($urandom())};
    for (int s = 0; s < NS; s++) sbox_words[s] = 16'($urandom_range(0, 65535));
  endtask

  task automatic zero_words();
    for (int t = 0; t < NT; t++) tile_words[t] = '0;
    for (int s = 0; s < NS; s++) sbox_words[s] = '0;
  endtask

  function automatic logic [63:0] all_outputs();
    return 64'({cfg_ready, tile_wr_en, tile_wr_addr, tile_wr_data, sbox_wr_en,
                sbox_wr_addr, sbox_wr_data, fabric_enable, busy, done, error});
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] x;
    reset_n   = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    cfg_bit   = 1'b0;
    cfg_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_outputs", all_outputs(), 64'd0);
    reset_n = 1'b1;
    sync();
    @(negedge clock);
    chk("idle_after_reset", {busy, cfg_ready, done, error}, 4'b0000);
    sync();

    // all-zero stream, good trailer 0x00
    zero_words();
    do_start();
    run_load(0, 8'h00, 0, -1);
    check_outcome("zero_good", 1'b1);

    // same stream, trailer 0x01
    do_start();
    run_load(0, 8'h01, 0, -1);
    check_outcome("zero_bad", 1'b0);

    // tile 0 = 1_0000_0001 with cfg_valid toggling
    zero_words();
    tile_words[0] = 33'h1_0000_0001;
    do_start();
    run_load(1, 8'h00, 0, -1);
    check_outcome("toggle_valid", 1'b1);

    // randomized streams, odd passes carry a corrupted trailer
    for (int r = 0; r < 6; r++) begin
      random_words();
      x = (r % 2 == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
      do_start();
      run_load(2, x, 0, -1);
      check_outcome("random", x == 8'h00);
    end

    // abort from DONE
    abort = 1'b1;
    sync();
    abort = 1'b0;
    @(negedge clock);
    chk("abort_from_done", {done, error, fabric_enable, busy}, 4'b0000);
    sync();

    // abort after 40 bits, with a bit offered in the same cycle
    random_words();
    do_start();
    run_load(2, 8'h00, 0, 40);
    abort     = 1'b1;
    cfg_valid = 1'b1;
    cfg_bit   = 1'($urandom_range(0, 1));
    sync();
    abort     = 1'b0;
    cfg_valid = 1'b0;
    @(negedge clock);
    chk("abort_idle", {busy, cfg_ready, done, error, fabric_enable}, 5'b00000);
    sync();
    repeat (4) sync();
    random_words();
    do_start();
    run_load(2, 8'h00, 0, -1);
    check_outcome("after_abort", 1'b1);

    // start during LOAD_TILE is ignored
    random_words();
    do_start();
    run_load(0, 8'h00, 0, 10);
    start = 1'b1;
    sync();
    start = 1'b0;
    run_load(0, 8'h00, 10, -1);
    check_outcome("start_ignored", 1'b1);

    // asynchronous reset in the middle of LOAD_SBOX
    random_words();
    do_start();
    run_load(0, 8'h00, 0, NT * TW + 5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", all_outputs(), 64'd0);
    sync();
    reset_n = 1'b1;
    sync();
    random_words();
    do_start();
    run_load(2, 8'h00, 0, -1);
    check_outcome("after_reset", 1'b1);

    repeat (3) sync();
    chk("tile_queue_drained", exp_tile_q.size(), 0);
    chk("sbox_queue_drained", exp_sbox_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
